scpu_ifetch: RTL and testbench
==============================

Name: scpu_ifetch

Overview:
- Instruction-fetch and PC stage directly upstream of the single-cycle control unit.
- Holds the PC and fetches instructions over a variable-latency req/ack instruction-memory port.
- Presents a stable instruction, and its OPcode/Fun fields, to control and the datapath.
- Computes the next PC from the control unit's Branch[1:0] and Jal decisions, and advances one instruction per cpu_en-qualified execute cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  main clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- cpu_en  input  1  CPU enable from debug control; 0 freezes the execute step.
- Branch  input  2  next-PC select from control: 00 seq, 01 branch taken, 10 jump/jal, 11 jr/jalr.
- rs_data  input  32  register rs value, used as the jr/jalr target.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch byte address.
- imem_ack  input  1  fetch data valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- inst  output  32  current instruction.
- OPcode  output  6  inst[31:26].
- Fun  output  6  inst[5:0].
- pc  output  32  address of inst.
- pc_plus4  output  32  pc+4, used as the jal/jalr link value.
- inst_valid  output  1  inst is valid and executing.
- commit  output  1  inst_valid & cpu_en; the datapath gates RegWrite and mem_w with it.
- pc_misalign  output  1  sticky flag: a jr target had nonzero bits [1:0].
- retire_cnt  output  CNT_W  count of executed (committed) instructions.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, inst=32'h0, inst_valid=0, imem_req=0.
  - pc_misalign=0, retire_cnt=0.
  - imem_req drops immediately, without waiting for a clock edge.
- FSM states IDLE, FETCH, EXEC:
  - IDLE: one cycle after reset release, then go to FETCH. Outputs keep their reset values.
  - FETCH: imem_req=1, imem_addr=pc (stable while req is high).
    - On a rising edge with imem_ack=1: inst<=imem_rdata, inst_valid<=1, go to EXEC.
    - Zero-wait memory (ack in the first FETCH cycle) gives a fetch latency of 1 cycle.
    - An N-cycle ack delay gives N+1 cycles.
    - cpu_en is ignored in FETCH; a started fetch is never cancelled.
  - EXEC: imem_req=0.
    - If cpu_en=1 at the edge: pc<=next_pc, retire_cnt<=retire_cnt+1, inst_valid<=0, go to FETCH.
    - If cpu_en=0: hold all state; inst, pc and inst_valid stay stable.
- Throughput is one instruction per 2 cycles with zero-wait memory.
- next_pc is combinational from the current pc, inst, Branch and rs_data:
  - 00: pc+4.
  - 01: pc+4 + (sign_extend(inst[15:0]) << 2).
  - 10: {pc_plus4[31:28], inst[25:0], 2'b00}.
  - 11: {rs_data[31:2], 2'b00}. If rs_data[1:0]!=0 at the commit edge, set pc_misalign (sticky until reset).
- Arithmetic is modulo 2^32: pc 32'hFFFF_FFFC sequential wraps to 0, and negative offsets wrap.
- retire_cnt wraps to 0 on overflow.
- pc bits [1:0] are always 0.
- imem_ack while not in FETCH is ignored; no state change, and imem_rdata is not captured.
- Reset asserted mid-FETCH or mid-EXEC: immediate return to the reset values. A pending ack is discarded.
- Branch is assumed stable during EXEC, since control decodes it combinationally from the held inst.

Decomposition:
- define.vh gets:
  - FSM state encodings: IF_IDLE, IF_FETCH, IF_EXEC.
  - Branch select encodings: NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_J=2'b10, NPC_JR=2'b11.
  - Default RESET_PC.
- One combinational sub-module, scpu_npc_gen: inputs pc, inst, Branch, rs_data; outputs next_pc, pc_plus4, jr_misalign.
- The FSM, registers and counter stay in scpu_ifetch.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: RESET_PC=0, release rst, zero-wait memory, cpu_en=1, Branch=00.
  - Response: IDLE 1 cycle, then imem_addr=0,4,8 on successive fetches; inst_valid high every other cycle; retire_cnt=3 after three EXECs.
- Wait states:
  - Stimulus: ack delayed 3 cycles.
  - Response: imem_req held 4 cycles with addr stable; inst_valid stays low until the capture edge.
- Branch back by one:
  - Stimulus: pc=0x10, inst[15:0]=16'hFFFF, Branch=01.
  - Response: next fetch addr 0x10.
- Jump and jr:
  - Jump: pc=0x4000_0000, inst[25:0]=26'h0000100, Branch=10 -> addr 0x4000_0400.
  - jr: Branch=11, rs_data=0x0000_0123 -> addr 0x120 and pc_misalign=1 (sticky).
- Stall: cpu_en=0 for 5 cycles in EXEC -> pc, inst and retire_cnt unchanged, commit=0; advances on the first cpu_en=1 edge.
- Wrap and reset mid-operation:
  - pc=0xFFFF_FFFC sequential -> next addr 0.
  - Assert rst during FETCH with ack pending -> imem_req=0 immediately, pc=RESET_PC, the late ack is ignored.

Source files
------------

// File: rtl/scpu_ifetch_pkg.sv
// Shared encodings for the instruction-fetch / PC stage.
package scpu_ifetch_pkg;

    // Fetch-stage FSM states.
    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_EXEC  = 2'd2
    } if_state_e;

    // Next-PC select encodings driven by the control unit on Branch[1:0].
    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    // Default PC loaded while reset is asserted.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch displacement: sign-extended 16-bit word offset turned into bytes.
    function automatic logic [31:0] br_byte_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/scpu_npc_gen.sv
// Combinational next-PC generator: sequential, branch, jump and register-jump
// targets, plus a flag for a register target that is not word aligned.
module scpu_npc_gen
    import scpu_ifetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] inst,        // instruction bits [25:0]: jump index / branch immediate
    input  logic [1:0]  Branch,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4,
    output logic        jr_misalign
);

    assign pc_plus4    = pc + 32'd4;
    assign jr_misalign = (Branch == NPC_JR) && (rs_data[1:0] != 2'b00);

    // Select the next PC; all additions wrap modulo 2^32.
    always_comb begin
        next_pc = pc_plus4;
        unique case (Branch)
            NPC_SEQ: next_pc = pc_plus4;
            NPC_BR:  next_pc = pc_plus4 + br_byte_offset(inst[15:0]);
            NPC_J:   next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
            NPC_JR:  next_pc = {rs_data[31:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/scpu_ifetch.sv
// Instruction fetch and PC stage: fetches over a req/ack port, holds the
// instruction stable while it executes, and steps the PC once per committed
// execute cycle.
module scpu_ifetch
    import scpu_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active low
    input  logic             cpu_en,
    input  logic [1:0]       Branch,
    input  logic [31:0]      rs_data,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    output logic [5:0]       OPcode,
    output logic [5:0]       Fun,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             inst_valid,
    output logic             commit,
    output logic             pc_misalign,
    output logic [CNT_W-1:0] retire_cnt
);

    if_state_e        r_state;
    if_state_e        w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_inst;
    logic             r_inst_valid;
    logic             r_pc_misalign;
    logic [CNT_W-1:0] r_retire_cnt;

    logic [31:0]      w_next_pc;
    logic [31:0]      w_pc_plus4;
    logic             w_jr_misalign;
    logic             w_exec_step;
    logic             w_capture;

    scpu_npc_gen u_npc_gen (
        .pc          (r_pc),
        .inst        (r_inst[25:0]),
        .Branch      (Branch),
        .rs_data     (rs_data),
        .next_pc     (w_next_pc),
        .pc_plus4    (w_pc_plus4),
        .jr_misalign (w_jr_misalign)
    );

    // An ack only counts in FETCH; cpu_en only counts in EXEC.
    assign w_capture   = (r_state == IF_FETCH) && imem_ack;
    assign w_exec_step = (r_state == IF_EXEC) && cpu_en;

    // State register; reset clears it asynchronously so imem_req drops at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IF_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> FETCH -> (ack) EXEC -> (cpu_en) FETCH.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IF_IDLE:  w_state_next = IF_FETCH;
            IF_FETCH: if (imem_ack) w_state_next = IF_EXEC;
            IF_EXEC:  if (cpu_en)   w_state_next = IF_FETCH;
            default:  w_state_next = IF_IDLE;
        endcase
    end

    // Instruction capture, PC step, sticky misalign flag and retire counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= {RESET_PC[31:2], 2'b00};
            r_inst        <= 32'h0;
            r_inst_valid  <= 1'b0;
            r_pc_misalign <= 1'b0;
            r_retire_cnt  <= '0;
        end else begin
            if (w_capture) begin
                r_inst       <= imem_rdata;
                r_inst_valid <= 1'b1;
            end
            if (w_exec_step) begin
                r_pc         <= w_next_pc;
                r_inst_valid <= 1'b0;
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
                if (w_jr_misalign) begin
                    r_pc_misalign <= 1'b1;
                end
            end
        end
    end

    assign imem_req    = (r_state == IF_FETCH);
    assign imem_addr   = r_pc;
    assign inst        = r_inst;
    assign OPcode      = r_inst[31:26];
    assign Fun         = r_inst[5:0];
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign inst_valid  = r_inst_valid;
    assign commit      = r_inst_valid & cpu_en;
    assign pc_misalign = r_pc_misalign;
    assign retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_scpu_ifetch.sv
// Directed bench for scpu_ifetch: expected fetch addresses are queued when an
// execute step is issued and popped when the DUT raises its next request.
module tb_scpu_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [1:0]  Branch;
    logic [31:0] rs_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [5:0]  OPcode;
    logic [5:0]  Fun;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        commit;
    logic        pc_misalign;
    logic [31:0] retire_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_retire;

    always #5 clk = ~clk;

    scpu_ifetch #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_en      (cpu_en),
        .Branch      (Branch),
        .rs_data     (rs_data),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .OPcode      (OPcode),
        .Fun         (Fun),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .inst_valid  (inst_valid),
        .commit      (commit),
        .pc_misalign (pc_misalign),
        .retire_cnt  (retire_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request and check its address against the scoreboard.
    task automatic wait_req(output logic [31:0] a);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'b0, imem_req}, 32'd1);
        a = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk("fetch_addr", imem_addr, a);
    endtask

    // Serve one fetch with 'delay' wait cycles, then check the captured instruction.
    task automatic fetch(input logic [31:0] word, input int delay);
        logic [31:0] a;
        wait_req(a);
        for (int d = 0; d < delay; d++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("wait_req_held", {31'b0, imem_req}, 32'd1);
            chk("wait_addr_stable", imem_addr, a);
            chk("wait_valid_low", {31'b0, inst_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        exp_pc     = a;
        exp_inst   = word;
        chk("cap_valid", {31'b0, inst_valid}, 32'd1);
        chk("cap_inst", inst, word);
        chk("cap_opcode", {26'b0, OPcode}, {26'b0, word[31:26]});
        chk("cap_fun", {26'b0, Fun}, {26'b0, word[5:0]});
        chk("cap_pc", pc, a);
        chk("cap_pc_plus4", pc_plus4, a + 32'd4);
        chk("exec_req_low", {31'b0, imem_req}, 32'd0);
        $display("fetch addr=%h inst=%h wait=%0d", a, word, delay);
    endtask

    // Execute the held instruction after 'stall' frozen cycles; queue the next address.
    task automatic exec(input logic [1:0] br, input logic [31:0] rs, input int stall,
                        input logic [31:0] next_addr);
        Branch  = br;
        rs_data = rs;
        cpu_en  = 1'b0;
        for (int s = 0; s < stall; s++) begin
            imem_ack   = 1'b1;             // stray ack outside FETCH must be ignored
            imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("stall_commit", {31'b0, commit}, 32'd0);
            chk("stall_pc", pc, exp_pc);
            chk("stall_inst", inst, exp_inst);
            chk("stall_valid", {31'b0, inst_valid}, 32'd1);
            chk("stall_retire", retire_cnt, exp_retire);
        end
        imem_ack = 1'b0;
        cpu_en   = 1'b1;
        #1;
        chk("commit_high", {31'b0, commit}, 32'd1);
        exp_q.push_back(next_addr);
        exp_retire = exp_retire + 32'd1;
        @(negedge clk);
        cpu_en = 1'b0;
        chk("post_exec_valid", {31'b0, inst_valid}, 32'd0);
        chk("retire_cnt", retire_cnt, exp_retire);
        $display("exec  pc=%h branch=%b rs=%h stall=%0d next=%h", exp_pc, br, rs, stall, next_addr);
    endtask

    initial begin
        logic [31:0] a;
        rst        = 1'b0;
        cpu_en     = 1'b0;
        Branch     = 2'b00;
        rs_data    = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        exp_retire = 32'd0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_misalign", {31'b0, pc_misalign}, 32'd0);

        // One IDLE cycle, then the first request.
        rst = 1'b1;
        #1;
        chk("idle_req_low", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        chk("idle_one_cycle", {31'b0, imem_req}, 32'd1);
        exp_q.push_back(32'h0);

        // Sequential fetches, the third with three wait states.
        fetch(32'h2008_0001, 0); exec(2'b00, 32'h0, 0, 32'h0000_0004);
        fetch(32'h2009_0002, 0); exec(2'b00, 32'h0, 0, 32'h0000_0008);
        fetch(32'h200A_0003, 3); exec(2'b00, 32'h0, 0, 32'h0000_000C);
        chk("retire_three", retire_cnt, 32'd3);
        fetch(32'h0000_0020, 0); exec(2'b00, 32'h0, 0, 32'h0000_0010);

        // Branch back by one instruction, after a five-cycle stall.
        fetch(32'h1000_FFFF, 0); exec(2'b01, 32'h0, 5, 32'h0000_0010);

        // Aligned jr into the upper region, then a jump within it.
        fetch(32'h0000_0008, 0); exec(2'b11, 32'h4000_0000, 0, 32'h4000_0000);
        chk("aligned_jr_no_flag", {31'b0, pc_misalign}, 32'd0);
        fetch(32'h0800_0100, 0); exec(2'b10, 32'h0, 0, 32'h4000_0400);

        // Misaligned jr target sets the sticky flag.
        fetch(32'h0000_0009, 0); exec(2'b11, 32'h0000_0123, 0, 32'h0000_0120);
        chk("misalign_set", {31'b0, pc_misalign}, 32'd1);

        // Wrap from the top of the address space.
        fetch(32'h0000_0008, 0); exec(2'b11, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
        fetch(32'h2000_0000, 0); exec(2'b00, 32'h0, 0, 32'h0000_0000);
        chk("misalign_sticky", {31'b0, pc_misalign}, 32'd1);
        fetch(32'h2001_0000, 0); exec(2'b00, 32'h0, 0, 32'h0000_0004);

        // Reset in the middle of a fetch, with a late ack pending.
        wait_req(a);
        imem_ack = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", {31'b0, inst_valid}, 32'd0);
        chk("midrst_retire", retire_cnt, 32'd0);
        chk("midrst_misalign", {31'b0, pc_misalign}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("late_ack_inst", inst, 32'h0);
        chk("late_ack_valid", {31'b0, inst_valid}, 32'd0);
        $display("reset during fetch at addr=%h", a);

        // Recovery from the reset PC.
        exp_q.delete();
        exp_q.push_back(32'h0);
        exp_retire = 32'd0;
        fetch(32'h2002_0000, 0); exec(2'b00, 32'h0, 0, 32'h0000_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
